// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path (and a later transmitter).
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  localparam logic [3:0] SAMPLE_LO  = 4'd7;
  localparam logic [3:0] SAMPLE_MID = 4'd8;
  localparam logic [3:0] SAMPLE_HI  = 4'd9;

  function automatic int unsigned calc_div(int unsigned clk_hz, int unsigned baud,
                                           int unsigned ovs);
    return clk_hz / (baud * ovs);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable via clear.
module uart_baud_tick #(
  parameter int unsigned DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with 16x oversampling, 3-sample majority vote and framing-error strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned OVS    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       we,
  output logic [7:0] character,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVS);

  logic       sync_q, rxs_q;
  state_t     state_q;
  logic [3:0] sample_q;
  logic [2:0] bit_idx_q;
  logic [7:0] shift_q, char_q;
  logic       s_lo_q, s_mid_q;
  logic       we_q, fe_q, busy_q;

  logic       tick, baud_clear, vote, vote_now;
  logic [3:0] sample_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      sync_q <= rxd;
      rxs_q  <= sync_q;
    end
  end

  // In BREAK the divider only runs while the line is high, so a tick means one full high tick.
  assign baud_clear = (state_q == IDLE) || ((state_q == BREAK) && !rxs_q);

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (tick)
  );

  // sample_nxt is the tick number being reached now; the vote lands on the 9th tick of a bit.
  assign sample_nxt = sample_q + 4'd1;
  assign vote       = (s_lo_q & s_mid_q) | (s_lo_q & rxs_q) | (s_mid_q & rxs_q);
  assign vote_now   = tick && (sample_nxt == SAMPLE_HI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sample_q  <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      char_q    <= '0;
      s_lo_q    <= 1'b1;
      s_mid_q   <= 1'b1;
      we_q      <= 1'b0;
      fe_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      fe_q <= 1'b0;
      if (tick) begin
        sample_q <= sample_nxt;
        if (sample_nxt == SAMPLE_LO)  s_lo_q  <= rxs_q;
        if (sample_nxt == SAMPLE_MID) s_mid_q <= rxs_q;
      end
      unique case (state_q)
        IDLE: begin
          if (!rxs_q) begin
            state_q   <= START;
            busy_q    <= 1'b1;
            sample_q  <= '0;
            bit_idx_q <= '0;
          end
        end
        START: begin
          if (vote_now) begin
            if (vote) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end
          end
        end
        DATA: begin
          if (vote_now) begin
            shift_q   <= {vote, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= STOP;
          end
        end
        STOP: begin
          if (vote_now) begin
            if (vote) begin
              char_q  <= shift_q;
              we_q    <= 1'b1;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              fe_q    <= 1'b1;
              state_q <= BREAK;
            end
          end
        end
        BREAK: begin
          if (tick) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign we        = we_q;
  assign character = char_q;
  assign frame_err = fe_q;
  assign busy      = busy_q;

endmodule
